// File: rtl/bcd_countdown_core_if.sv
// Control pulses in and BCD display/status out for bcd_countdown_core.
// master drives the buttons (debouncers/bench); slave is the timer core.
interface bcd_countdown_core_if;
    logic       start;
    logic       clear;
    logic       inc;
    logic       dec;
    logic       field;
    logic       mode;
    logic [3:0] bin0;
    logic [3:0] bin1;
    logic [3:0] bin2;
    logic [3:0] bin3;
    logic [1:0] state;
    logic       tick;
    logic       expired;
    logic       alarm;

    modport master (
        output start, clear, inc, dec, field, mode,
        input  bin0, bin1, bin2, bin3, state, tick, expired, alarm
    );

    modport slave (
        input  start, clear, inc, dec, field, mode,
        output bin0, bin1, bin2, bin3, state, tick, expired, alarm
    );
endinterface

// File: rtl/bcd_countdown_core.sv
// MM:SS BCD timer core: countdown / count-up, pause, per-field set with wrap,
// preset restore and a timed alarm on expiry. All outputs are registered.
module bcd_countdown_core #(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned MIN_LIMIT    = 59,
    parameter int unsigned ALARM_CYCLES = 100_000_000
) (
    input logic                 clk,
    input logic                 reset,
    bcd_countdown_core_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ALARM_CYCLES + 1);
    localparam logic [PW-1:0] LAST  = PW'(TICK_DIV - 1);
    localparam logic [3:0]    LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0]    LIM_O = 4'(MIN_LIMIT % 10);

    typedef enum logic [1:0] {
        S_SET   = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_EXP   = 2'b11
    } state_t;

    state_t           st, st_n;
    logic [3:0][3:0]  dig, dig_n;      // [0] sec ones .. [3] min tens
    logic [3:0][3:0]  pre, pre_n;
    logic [3:0][3:0]  up, down, adj;
    logic [PW-1:0]    presc, presc_n;
    logic [AW-1:0]    acnt, acnt_n;
    logic             mode_q, mode_n;
    logic             tick_q, tick_n;
    logic             exp_q, exp_n;
    logic             alarm_q, alarm_n;
    logic             at_limit, at_one;

    assign at_limit = (dig[3] == LIM_T) && (dig[2] == LIM_O) && (dig[1] == 4'd5) && (dig[0] == 4'd9);
    assign at_one   = (dig[3] == 4'd0) && (dig[2] == 4'd0) && (dig[1] == 4'd0) && (dig[0] == 4'd1);

    // BCD step values for RUN, and the SET-mode field adjust (no cross-field carry)
    always_comb begin
        up   = dig;
        down = dig;
        adj  = dig;
        if (dig[0] != 4'd9) up[0] = dig[0] + 4'd1;
        else begin
            up[0] = 4'd0;
            if (dig[1] != 4'd5) up[1] = dig[1] + 4'd1;
            else begin
                up[1] = 4'd0;
                if (dig[2] != 4'd9) up[2] = dig[2] + 4'd1;
                else begin
                    up[2] = 4'd0;
                    up[3] = dig[3] + 4'd1;
                end
            end
        end
        if (dig[0] != 4'd0) down[0] = dig[0] - 4'd1;
        else begin
            down[0] = 4'd9;
            if (dig[1] != 4'd0) down[1] = dig[1] - 4'd1;
            else begin
                down[1] = 4'd5;
                if (dig[2] != 4'd0) down[2] = dig[2] - 4'd1;
                else begin
                    down[2] = 4'd9;
                    down[3] = dig[3] - 4'd1;
                end
            end
        end
        if (!bus.field && bus.inc) begin
            if (dig[0] != 4'd9) adj[0] = dig[0] + 4'd1;
            else begin
                adj[0] = 4'd0;
                adj[1] = (dig[1] == 4'd5) ? 4'd0 : dig[1] + 4'd1;
            end
        end else if (!bus.field) begin
            if (dig[0] != 4'd0) adj[0] = dig[0] - 4'd1;
            else begin
                adj[0] = 4'd9;
                adj[1] = (dig[1] == 4'd0) ? 4'd5 : dig[1] - 4'd1;
            end
        end else if (bus.inc) begin
            if (dig[3] == LIM_T && dig[2] == LIM_O) begin
                adj[3] = 4'd0;
                adj[2] = 4'd0;
            end else if (dig[2] == 4'd9) begin
                adj[2] = 4'd0;
                adj[3] = dig[3] + 4'd1;
            end else adj[2] = dig[2] + 4'd1;
        end else begin
            if (dig[3] == 4'd0 && dig[2] == 4'd0) begin
                adj[3] = LIM_T;
                adj[2] = LIM_O;
            end else if (dig[2] == 4'd0) begin
                adj[2] = 4'd9;
                adj[3] = dig[3] - 4'd1;
            end else adj[2] = dig[2] - 4'd1;
        end
    end

    always_comb begin
        st_n    = st;
        dig_n   = dig;
        pre_n   = pre;
        presc_n = presc;
        acnt_n  = acnt;
        mode_n  = mode_q;
        exp_n   = 1'b0;
        case (st)
            S_SET: begin
                if (bus.clear) begin
                    dig_n = '0;
                    pre_n = '0;
                end else if (bus.start) begin
                    if (bus.mode || dig != '0) begin
                        pre_n   = dig;
                        mode_n  = bus.mode;
                        presc_n = '0;
                        st_n    = S_RUN;
                    end
                end else if (bus.inc ^ bus.dec) begin
                    dig_n = adj;
                end
            end
            S_RUN: begin
                if (bus.clear) begin
                    st_n  = S_SET;
                    dig_n = pre;
                end else if (bus.start) begin
                    st_n = S_PAUSE;
                end else if (presc == LAST) begin
                    presc_n = '0;
                    if (mode_q) begin
                        if (at_limit) st_n = S_EXP;
                        else dig_n = up;
                    end else begin
                        dig_n = down;
                        if (at_one) st_n = S_EXP;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (bus.clear) begin
                    st_n  = S_SET;
                    dig_n = pre;
                end else if (bus.start) begin
                    st_n = S_RUN;
                end
            end
            default: begin
                if (bus.clear || bus.start) begin
                    st_n   = S_SET;
                    dig_n  = pre;
                    acnt_n = '0;
                end else if (acnt != '0) begin
                    acnt_n = acnt - AW'(1);
                end
            end
        endcase
        if (st != S_EXP && st_n == S_EXP) begin
            acnt_n = AW'(ALARM_CYCLES);
            exp_n  = 1'b1;
        end
        alarm_n = (st_n == S_EXP) && (acnt_n != '0);
        tick_n  = (st_n == S_RUN) && (presc_n == LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= S_SET;
            dig     <= '0;
            pre     <= '0;
            presc   <= '0;
            acnt    <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            exp_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            st      <= st_n;
            dig     <= dig_n;
            pre     <= pre_n;
            presc   <= presc_n;
            acnt    <= acnt_n;
            mode_q  <= mode_n;
            tick_q  <= tick_n;
            exp_q   <= exp_n;
            alarm_q <= alarm_n;
        end
    end

    assign bus.bin0    = dig[0];
    assign bus.bin1    = dig[1];
    assign bus.bin2    = dig[2];
    assign bus.bin3    = dig[3];
    assign bus.state   = st;
    assign bus.tick    = tick_q;
    assign bus.expired = exp_q;
    assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_bcd_countdown_core.sv
// Directed bench for bcd_countdown_core with TICK_DIV=4, ALARM_CYCLES=6, MIN_LIMIT=59.
// Digits are compared as a 16-bit hex MM:SS word {bin3,bin2,bin1,bin0}.
module tb_bcd_countdown_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    bcd_countdown_core_if bus ();

    bcd_countdown_core #(
        .TICK_DIV(4),
        .MIN_LIMIT(59),
        .ALARM_CYCLES(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.bin3, bus.bin2, bus.bin1, bus.bin0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
    endtask

    task automatic press_clear();
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    endtask

    task automatic press_inc(input logic f, input int unsigned n);
        bus.field = f;
        for (int unsigned i = 0; i < n; i++) begin
            bus.inc = 1'b1; cyc(); bus.inc = 1'b0;
        end
    endtask

    task automatic press_dec(input logic f, input int unsigned n);
        bus.field = f;
        for (int unsigned i = 0; i < n; i++) begin
            bus.dec = 1'b1; cyc(); bus.dec = 1'b0;
        end
    endtask

    initial begin
        int  n;
        logic moved;
        bus.start = 0; bus.clear = 0; bus.inc = 0; bus.dec = 0;
        bus.field = 0; bus.mode = 0;

        // reset state
        #12;
        chk("rst_state", bus.state, 2'b00);
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_flags", {bus.tick, bus.expired, bus.alarm}, 3'b000);
        @(posedge clk); #1 reset = 1'b1;
        cyc();

        // set and wrap
        press_dec(1'b0, 1);  chk("sec_dec_wrap", digits(), 16'h0059);
        press_inc(1'b0, 1);  chk("sec_inc_wrap", digits(), 16'h0000);
        press_dec(1'b1, 1);  chk("min_dec_wrap", digits(), 16'h5900);
        bus.inc = 1; bus.dec = 1; cyc(); bus.inc = 0; bus.dec = 0;
        chk("inc_dec_same", digits(), 16'h5900);
        press_inc(1'b1, 1);  chk("min_inc_wrap", digits(), 16'h0000);

        // start at 00:00 in countdown is ignored
        press_start();
        chk("start_zero", bus.state, 2'b00);

        // countdown 00:02 to expiry
        press_inc(1'b0, 2);  chk("preset_2s", digits(), 16'h0002);
        press_start();
        chk("run_state", bus.state, 2'b01);
        chk("tick_c1", bus.tick, 1'b0);
        cyc(); cyc();
        chk("tick_c3", bus.tick, 1'b0);
        cyc();
        chk("tick_c4", bus.tick, 1'b1);
        chk("digits_c4", digits(), 16'h0002);
        cyc();
        chk("tick_c5", bus.tick, 1'b0);
        chk("digits_0001", digits(), 16'h0001);
        cyc(); cyc(); cyc();
        chk("tick_c8", bus.tick, 1'b1);
        cyc();
        chk("exp_state", bus.state, 2'b11);
        chk("exp_pulse", bus.expired, 1'b1);
        chk("exp_digits", digits(), 16'h0000);
        n = 0;
        while (bus.alarm && n < 20) begin
            n++;
            cyc();
            if (n == 1) chk("exp_one_cycle", bus.expired, 1'b0);
        end
        chk("alarm_len", n, 6);
        chk("exp_hold", bus.state, 2'b11);
        press_start();
        chk("ack_state", bus.state, 2'b00);
        chk("ack_digits", digits(), 16'h0002);

        // borrow chain 10:00 -> 09:59
        press_clear();
        press_inc(1'b1, 10); chk("preset_10m", digits(), 16'h1000);
        press_start();
        cyc(); cyc(); cyc(); cyc();
        chk("borrow", digits(), 16'h0959);
        press_clear();
        chk("run_clear_state", bus.state, 2'b00);
        chk("run_clear_digits", digits(), 16'h1000);

        // pause two cycles into a tick period, hold, resume
        press_clear();
        press_inc(1'b1, 1);
        press_start();
        cyc(); cyc();
        press_start();
        chk("pause_state", bus.state, 2'b10);
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (digits() !== 16'h0100 || bus.tick !== 1'b0) moved = 1'b1;
            cyc();
        end
        chk("pause_hold", moved, 1'b0);
        press_start();
        chk("resume_state", bus.state, 2'b01);
        chk("resume_r1_tick", bus.tick, 1'b0);
        cyc();
        chk("resume_r2_tick", bus.tick, 1'b1);
        cyc();
        chk("resume_step", digits(), 16'h0059);
        press_clear();
        chk("pause_clear", {14'h0, bus.state, digits()}, {14'h0, 2'b00, 16'h0100});

        // count-up limit
        press_clear();
        press_dec(1'b1, 1);
        press_dec(1'b0, 2);
        chk("preset_5958", digits(), 16'h5958);
        bus.mode = 1'b1;
        press_start();
        bus.mode = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("up_5959", digits(), 16'h5959);
        chk("up_state", bus.state, 2'b01);
        cyc(); cyc(); cyc(); cyc();
        chk("up_exp_state", bus.state, 2'b11);
        chk("up_exp_digits", digits(), 16'h5959);
        chk("up_exp_pulse", bus.expired, 1'b1);

        // asynchronous reset mid-alarm
        cyc();
        chk("alarm_before_rst", bus.alarm, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", bus.state, 2'b00);
        chk("async_rst_out", {bus.tick, bus.expired, bus.alarm, digits()}, 19'h0);
        @(posedge clk); #1 reset = 1'b1;
        cyc();

        // clear and start together in RUN
        press_inc(1'b0, 3);
        press_start();
        cyc();
        bus.start = 1; bus.clear = 1; cyc(); bus.start = 0; bus.clear = 0;
        chk("clr_start_state", bus.state, 2'b00);
        chk("clr_start_digits", digits(), 16'h0003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_countdown_core.md
# bcd_countdown_core

Parametrised MM:SS timer core that succeeds the fixed countdown timer. It supports countdown and count-up (stopwatch) modes, run/pause control and per-field set with inc/dec and wrap. It also restores a stored preset and raises a timed alarm on expiry. It sits between the push-button debouncers (clean single-cycle pulses in) and SegDisplay (four BCD digits out).

## Interface
- TICK_DIV, default 50_000_000: clk cycles per one-second tick; must be ≥ 2.
- MIN_LIMIT, default 59: maximum minutes value, 1..99.
- ALARM_CYCLES, default 100_000_000: cycles the alarm stays high after expiry; must be ≥ 1.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: start / pause / resume / acknowledge.
- clear  in  1  single-cycle pulse: return to SET.
- inc  in  1  single-cycle pulse: increment the selected field (SET only).
- dec  in  1  single-cycle pulse: decrement the selected field (SET only).
- field  in  1  0 = seconds, 1 = minutes.
- mode  in  1  0 = countdown, 1 = count-up; sampled only on SET→RUN.
- bin0, bin1, bin2, bin3  out  4 each  BCD digits: seconds ones, seconds tens, minutes ones, minutes tens.
- state  out  2  00 SET, 01 RUN, 10 PAUSE, 11 EXPIRED.
- tick  out  1  one-cycle pulse on each prescaler wrap in RUN.
- expired  out  1  one-cycle pulse on the first cycle of EXPIRED.
- alarm  out  1  high while the alarm timer is active.

## Operation
- Reset (reset=0, asynchronous): all digits 0, preset 0, state SET, prescaler 0, alarm counter 0, latched mode 0. Outputs tick, expired and alarm are 0.
- Input priority per cycle: clear > start > inc/dec. If inc and dec are both high in the same cycle, there is no change.
- **SET state**
  - inc/dec adjust only the selected field.
  - Seconds wrap 59↔00 with no carry into minutes.
  - Minutes wrap MIN_LIMIT↔00.
  - clear zeroes all digits and the preset.
  - start, when mode=1 or the time is nonzero:
    - copy the digits into the preset;
    - latch mode;
    - clear the prescaler;
    - go to RUN.
  - start in countdown mode at 00:00 is ignored and the state stays SET.
- **RUN state**
  - The prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1, tick=1 and the digits step on the same edge the prescaler returns to 0.
  - Countdown: the value decrements with BCD borrow (sec ones 0→9, sec tens 0→5, min ones 0→9 with min tens borrow).
    - A tick taking the value 00:01→00:00 also moves the state to EXPIRED.
  - Count-up: the value increments with BCD carry.
    - A tick at MIN_LIMIT:59 leaves the value unchanged and moves the state to EXPIRED.
  - start → PAUSE.
  - clear → SET with digits restored from the preset.
  - inc/dec are ignored.
- **PAUSE state**
  - The prescaler and digits hold their values.
  - start → RUN, and the prescaler resumes from its held value (the partial second is preserved).
  - clear → SET with digits restored from the preset.
  - inc/dec are ignored.
- **EXPIRED state**
  - The digits hold their final value.
  - On entry the alarm counter loads ALARM_CYCLES and alarm=1. The counter decrements each cycle and alarm falls when it reaches 0.
  - start or clear → SET with digits restored from the preset. alarm drops the same edge.
- Widths:
  - prescaler: $clog2(TICK_DIV) bits;
  - alarm counter: $clog2(ALARM_CYCLES+1) bits.
  - Digit arithmetic is 4-bit BCD and never holds a value >9 (ones) or >5 (seconds tens).

## Timing
- All outputs are registered. state, the digits, tick, expired and alarm change only on clk edges, except on asynchronous reset.
- Pulse inputs act on the edge where they are sampled high. The state change is visible the next cycle.
- First tick after start is TICK_DIV cycles after the start edge. The first digit change is visible TICK_DIV cycles after state reads RUN.
- expired goes high in the same cycle state first reads 11, and lasts exactly one cycle.
- alarm is high for exactly ALARM_CYCLES cycles, beginning with the first EXPIRED cycle, unless it is cut short by start/clear.
- Reset mid-RUN or mid-alarm: state SET and all outputs 0 immediately. No partial tick is emitted after reset release.
- clear and start in the same cycle: clear wins.

## Test plan
- Use TICK_DIV=4, ALARM_CYCLES=6, MIN_LIMIT=59 throughout.
- Set and wrap, in SET:
  - field=0, dec ×1 from 00:00 → 00:59;
  - inc → 00:00;
  - field=1, dec → 59:00;
  - inc and dec in the same cycle → no change.
- Countdown expiry: preset 00:02, start:
  - ticks every 4 cycles;
  - digits 00:01 then 00:00;
  - state=11 with expired=1 for one cycle;
  - alarm high exactly 6 cycles;
  - start → SET showing 00:02.
- Borrow chain: preset 10:00, one tick → 09:59 (bin3=0, bin2=9, bin1=5, bin0=9).
- Pause/resume: preset 01:00, start, pause 2 cycles into a tick period, hold 20 cycles:
  - no digit change during the hold;
  - after resume the next tick arrives 2 cycles later;
  - clear → 01:00, state SET.
- Count-up limit: mode=1, preset 59:58, start:
  - 59:59 after one tick;
  - EXPIRED on the next tick with digits held at 59:59.
- Guards:
  - start at 00:00 in countdown → state stays SET;
  - reset low mid-alarm → all outputs 0 asynchronously;
  - clear+start in the same cycle in RUN → SET.
